// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the BCD converter arbiter and its round-robin picker.
package bcd_conv_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DP_W       = 3;

    // Index NUM_DIGITS-1 is the most significant digit.
    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bcd_digits_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c
);

    int unsigned       pos;
    logic [IDX_W-1:0]  pos_idx;

    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos     = (32'(rr_ptr) + i) % N_REQ;
            pos_idx = IDX_W'(pos);
            if (!found_c && req[pos_idx]) begin
                found_c = 1'b1;
                idx_c   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sharing of one auto-scaling binary-to-BCD converter among N_REQ requesters.
// Optional converter watchdog: define CONV_TIMEOUT_EN.
module bcd_conv_arbiter
    import bcd_conv_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned BIN_W       = 20,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ-1:0][BIN_W-1:0]     req_bin,
    output logic [N_REQ-1:0]                rsp_valid,
    output bcd_digits_t                     rsp_bcd,
    output logic [DP_W-1:0]                 rsp_dp,
    output logic                            rsp_err,
    output logic                            busy,
    output logic [$clog2(N_REQ)-1:0]        grant_idx,
    output logic                            conv_start,
    output logic [BIN_W-1:0]                conv_bin,
    input  logic                            conv_ready,
    input  logic                            conv_done,
    input  bcd_digits_t                     conv_bcd,
    input  logic [DP_W-1:0]                 conv_dp
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("bcd_conv_arbiter: parameter out of range");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [BIN_W-1:0]   conv_bin_q, conv_bin_d;
    logic               conv_start_q, conv_start_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    bcd_digits_t        rsp_bcd_q, rsp_bcd_d;
    logic [DP_W-1:0]    rsp_dp_q, rsp_dp_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;

    logic               pick_found_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [BIN_W-1:0]   pick_bin_c;
    logic               go_c;
    logic               zero_c;
    logic               timeout_c;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .found_c (pick_found_c),
        .idx_c   (pick_idx_c)
    );

    assign pick_bin_c = req_bin[pick_idx_c];
    assign go_c       = (state_q == ST_IDLE) && pick_found_c && conv_ready;
    // The converter never finishes on 0, so zero operands bypass it.
    assign zero_c     = (pick_bin_c == '0);

`ifdef CONV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts WAIT cycles; cleared everywhere else.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout_c = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (go_c) state_d = zero_c ? ST_RESP : ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (conv_done || timeout_c) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_idx_d  = grant_idx_q;
        conv_bin_d   = conv_bin_q;
        conv_start_d = 1'b0;
        rsp_valid_d  = '0;
        rsp_bcd_d    = rsp_bcd_q;
        rsp_dp_d     = rsp_dp_q;
        rsp_err_d    = rsp_err_q;
        rr_ptr_d     = rr_ptr_q;
        busy_d       = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (go_c) begin
                    grant_idx_d = pick_idx_c;
                    conv_bin_d  = pick_bin_c;
                    if (zero_c) begin
                        rsp_bcd_d   = '0;
                        rsp_dp_d    = '0;
                        rsp_err_d   = 1'b0;
                        rsp_valid_d = N_REQ'(1) << pick_idx_c;
                    end else begin
                        conv_start_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (conv_done) begin
                    rsp_bcd_d   = conv_bcd;
                    rsp_dp_d    = conv_dp;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = N_REQ'(1) << grant_idx_q;
                end else if (timeout_c) begin
                    rsp_bcd_d   = '1;
                    rsp_dp_d    = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = N_REQ'(1) << grant_idx_q;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
            conv_bin_q   <= '0;
            conv_start_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_bcd_q    <= '0;
            rsp_dp_q     <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            conv_bin_q   <= conv_bin_d;
            conv_start_q <= conv_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_bcd_q    <= rsp_bcd_d;
            rsp_dp_q     <= rsp_dp_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_bcd    = rsp_bcd_q;
    assign rsp_dp     = rsp_dp_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign grant_idx  = grant_idx_q;
    assign conv_start = conv_start_q;
    assign conv_bin   = conv_bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter with a behavioural auto-scaling converter model.
// The watchdog sequence is included when CONV_TIMEOUT_EN is defined.
module tb_bcd_conv_arbiter;
    import bcd_conv_pkg::*;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned BIN_W       = 20;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned CONV_LAT    = 6;

    logic                        clk;
    logic                        rst_n;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][BIN_W-1:0] req_bin;
    logic [N_REQ-1:0]            rsp_valid;
    bcd_digits_t                 rsp_bcd;
    logic [DP_W-1:0]             rsp_dp;
    logic                        rsp_err;
    logic                        busy;
    logic [1:0]                  grant_idx;
    logic                        conv_start;
    logic [BIN_W-1:0]            conv_bin;
    logic                        conv_ready;
    logic                        conv_done;
    bcd_digits_t                 conv_bcd;
    logic [DP_W-1:0]             conv_dp;

    bcd_conv_arbiter #(
        .N_REQ       (N_REQ),
        .BIN_W       (BIN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_bin    (req_bin),
        .rsp_valid  (rsp_valid),
        .rsp_bcd    (rsp_bcd),
        .rsp_dp     (rsp_dp),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .grant_idx  (grant_idx),
        .conv_start (conv_start),
        .conv_bin   (conv_bin),
        .conv_ready (conv_ready),
        .conv_done  (conv_done),
        .conv_bcd   (conv_bcd),
        .conv_dp    (conv_dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter model: digits left-justified, dp counts the shifts (max 7).
    function automatic logic [34:0] model_conv(input logic [BIN_W-1:0] v);
        int unsigned x;
        int unsigned s;
        bcd_digits_t d;
        x = 32'(v);
        for (int i = 0; i < 8; i++) begin
            d[i] = 4'(x % 10);
            x    = x / 10;
        end
        s = 0;
        while (s < 7 && d[7] == 4'd0) begin
            d = d << 4;
            s++;
        end
        return {3'(s), d};
    endfunction

    logic             m_busy;
    int               m_cnt;
    logic [BIN_W-1:0] m_bin;
    logic             tb_ready_block;
    logic             tb_hang;

    assign conv_ready = !m_busy && !tb_ready_block;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_bin     <= '0;
            conv_done <= 1'b0;
            conv_bcd  <= '0;
            conv_dp   <= '0;
        end else begin
            conv_done <= 1'b0;
            if (conv_start && !m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= CONV_LAT;
                m_bin  <= conv_bin;
            end else if (m_busy && !tb_hang) begin
                if (m_cnt == 1) begin
                    m_busy              <= 1'b0;
                    conv_done           <= 1'b1;
                    {conv_dp, conv_bcd} <= model_conv(m_bin);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != '0) ok = 1'b1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && rsp_valid == '0) break;
        end
    endtask

    typedef struct {
        int unsigned      idx;
        logic [BIN_W-1:0] bin;
        logic [31:0]      exp_bcd;
        logic [2:0]       exp_dp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit          ok;
        int          cyc;
        logic [3:0]  exp_v;
        bit          bad;
        bit          started;

        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{idx: 0, bin: 20'd12345,   exp_bcd: 32'h1234_5000, exp_dp: 3'd3};
        vecs[1] = '{idx: 2, bin: 20'd7,       exp_bcd: 32'h7000_0000, exp_dp: 3'd7};
        vecs[2] = '{idx: 1, bin: 20'd0,       exp_bcd: 32'h0000_0000, exp_dp: 3'd0};
        vecs[3] = '{idx: 3, bin: 20'd1048575, exp_bcd: 32'h1048_5750, exp_dp: 3'd1};
        vecs[4] = '{idx: 1, bin: 20'd999999,  exp_bcd: 32'h9999_9900, exp_dp: 3'd2};
        vecs[5] = '{idx: 0, bin: 20'd1,       exp_bcd: 32'h1000_0000, exp_dp: 3'd7};
        vecs[6] = '{idx: 3, bin: 20'd100,     exp_bcd: 32'h1000_0000, exp_dp: 3'd5};
        vecs[7] = '{idx: 2, bin: 20'd505050,  exp_bcd: 32'h5050_5000, exp_dp: 3'd2};

        rst_n          = 1'b0;
        req_valid      = '0;
        req_bin        = '0;
        tb_ready_block = 1'b0;
        tb_hang        = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",       32'(busy),       32'd0);
        check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        check("rst_rsp_bcd",    32'(rsp_bcd),    32'd0);
        check("rst_rsp_dp",     32'(rsp_dp),     32'd0);
        check("rst_rsp_err",    32'(rsp_err),    32'd0);
        check("rst_conv_start", 32'(conv_start), 32'd0);
        check("rst_conv_bin",   32'(conv_bin),   32'd0);
        check("rst_grant_idx",  32'(grant_idx),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two requesters at once: index 0 first, then index 2.
        req_bin[0] = 20'd12345;
        req_bin[2] = 20'd7;
        req_valid  = 4'b0101;
        wait_rsp(ok, cyc);
        check("pair1_seen",  32'(ok),        32'd1);
        check("pair1_valid", 32'(rsp_valid), 32'h1);
        check("pair1_bcd",   32'(rsp_bcd),   32'h1234_5000);
        check("pair1_dp",    32'(rsp_dp),    32'd3);
        req_valid[0] = 1'b0;
        wait_rsp(ok, cyc);
        check("pair2_seen",  32'(ok),        32'd1);
        check("pair2_valid", 32'(rsp_valid), 32'h4);
        check("pair2_bcd",   32'(rsp_bcd),   32'h7000_0000);
        check("pair2_dp",    32'(rsp_dp),    32'd7);
        req_valid = '0;
        wait_idle();

        // Table of single-requester conversions.
        for (int k = 0; k < 8; k++) begin
            req_bin[vecs[k].idx] = vecs[k].bin;
            req_valid            = 4'b0001 << vecs[k].idx;
            exp_v                = 4'b0001 << vecs[k].idx;
            wait_rsp(ok, cyc);
            check($sformatf("vec%0d_seen", k),  32'(ok),        32'd1);
            check($sformatf("vec%0d_valid", k), 32'(rsp_valid), 32'(exp_v));
            check($sformatf("vec%0d_bcd", k),   32'(rsp_bcd),   vecs[k].exp_bcd);
            check($sformatf("vec%0d_dp", k),    32'(rsp_dp),    32'(vecs[k].exp_dp));
            check($sformatf("vec%0d_err", k),   32'(rsp_err),   32'd0);
            req_valid = '0;
            wait_idle();
        end

        // Zero operand: no converter start, response in the cycle after the granting IDLE cycle.
        req_bin[1] = 20'd0;
        req_valid  = 4'b0010;
        started    = 1'b0;
        ok         = 1'b0;
        cyc        = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (conv_start) started = 1'b1;
            if (rsp_valid != '0) ok = 1'b1;
        end
        check("zero_seen",  32'(ok),        32'd1);
        check("zero_lat",   32'(cyc),       32'd1);
        check("zero_start", 32'(started),   32'd0);
        check("zero_valid", 32'(rsp_valid), 32'h2);
        check("zero_bcd",   32'(rsp_bcd),   32'd0);
        check("zero_dp",    32'(rsp_dp),    32'd0);
        req_valid = '0;
        wait_idle();

        // Converter not ready: arbitration stalls until ready returns.
        tb_ready_block = 1'b1;
        req_bin[0]     = 20'd55;
        req_valid      = 4'b0001;
        bad            = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || conv_start) bad = 1'b1;
        end
        check("stall_idle", 32'(bad), 32'd0);
        tb_ready_block = 1'b0;
        @(negedge clk);
        check("stall_busy",  32'(busy),       32'd1);
        check("stall_start", 32'(conv_start), 32'd1);
        wait_rsp(ok, cyc);
        check("stall_valid", 32'(rsp_valid), 32'h1);
        check("stall_bcd",   32'(rsp_bcd),   32'h5500_0000);
        check("stall_dp",    32'(rsp_dp),    32'd6);
        req_valid = '0;
        wait_idle();

        // Reset during WAIT clears everything; next grant goes to the lowest index.
        req_bin[2] = 20'd4321;
        req_valid  = 4'b0100;
        ok         = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (conv_start) ok = 1'b1;
        end
        check("wrst_start_seen", 32'(ok), 32'd1);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("wrst_busy",      32'(busy),       32'd0);
        check("wrst_start",     32'(conv_start), 32'd0);
        check("wrst_rsp_valid", 32'(rsp_valid),  32'd0);
        check("wrst_rsp_bcd",   32'(rsp_bcd),    32'd0);
        rst_n      = 1'b1;
        req_bin[1] = 20'd42;
        req_bin[3] = 20'd43;
        req_valid  = 4'b1010;
        @(negedge clk);
        check("wrst_grant", 32'(grant_idx), 32'd1);
        wait_rsp(ok, cyc);
        check("wrst_valid", 32'(rsp_valid), 32'h2);
        check("wrst_bcd",   32'(rsp_bcd),   32'h4200_0000);
        req_valid = '0;
        wait_idle();

        // All four held: order 0,1,2,3,0 with an idle gap after every response.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        req_bin[0] = 20'd11;
        req_bin[1] = 20'd22;
        req_bin[2] = 20'd33;
        req_bin[3] = 20'd44;
        req_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_v = 4'b0001 << (k % 4);
            wait_rsp(ok, cyc);
            check($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'(exp_v));
            @(negedge clk);
            check($sformatf("rr%0d_gap", k),   32'(rsp_valid), 32'd0);
        end
        req_valid = '0;
        wait_idle();

`ifdef CONV_TIMEOUT_EN
        // Hung converter: error response after TIMEOUT_CYC WAIT cycles, then no further grants.
        tb_hang    = 1'b1;
        req_bin[0] = 20'd999;
        req_valid  = 4'b0001;
        ok         = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (conv_start) ok = 1'b1;
        end
        check("to_start_seen", 32'(ok), 32'd1);
        wait_rsp(ok, cyc);
        check("to_wait_cycles", 32'(cyc - 1),   32'(TIMEOUT_CYC));
        check("to_valid",       32'(rsp_valid), 32'h1);
        check("to_err",         32'(rsp_err),   32'd1);
        check("to_bcd",         32'(rsp_bcd),   32'hFFFF_FFFF);
        check("to_dp",          32'(rsp_dp),    32'd0);
        req_valid  = '0;
        @(negedge clk);
        req_valid  = 4'b0001;
        bad        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || conv_start) bad = 1'b1;
        end
        check("to_stuck_idle", 32'(bad), 32'd0);
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        tb_hang = 1'b0;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
